// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pipe_ctrl_if
// Brief   : Control/status bundle between the pipeline sequencer and datapath
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 32
);
  logic              fetch_valid;
  logic [STAGES-1:0] stall_req;
  logic              hazard;
  logic              br_taken;
  logic              cnt_clr;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_valid;
  logic              flush;
  logic              retire;
  logic [CNT_W-1:0]  retired_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output fetch_valid, stall_req, hazard, br_taken, cnt_clr,
    input  stage_en, stage_valid, flush, retire,
    input  retired_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  fetch_valid, stall_req, hazard, br_taken, cnt_clr,
    output stage_en, stage_valid, flush, retire,
    output retired_cnt, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pipe_ctrl
// Brief   : N-stage pipeline sequencer: valid tracking, load enables, flush,
//           bubbles, retirement; counters built when PIPE_PERF_CNT_EN defined
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int STAGES      = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int HAZ_STAGE   = 1,
  parameter int CNT_W       = 32
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pipe_ctrl_if.slave bus
);

  logic [STAGES-1:0] w_stall_eff;
  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:1] r_valid;
  logic              w_flush;
  logic              w_retire;
  logic              w_acc;

  assign w_stall_eff = bus.stall_req | (STAGES'(bus.hazard) << HAZ_STAGE);

  // A stall anywhere downstream freezes every earlier stage.
  always_comb begin
    w_acc  = 1'b0;
    w_hold = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      w_acc     = w_acc | w_stall_eff[k];
      w_hold[k] = w_acc;
    end
  end

  assign w_v      = {r_valid, bus.fetch_valid};
  assign w_flush  = bus.br_taken & ~w_hold[FLUSH_DEPTH];
  assign w_retire = w_v[STAGES-1] & ~w_hold[STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        if (w_flush && (k <= FLUSH_DEPTH))
          r_valid[k] <= 1'b0;
        else if (w_hold[k])
          r_valid[k] <= r_valid[k];
        else if (w_hold[k-1])
          r_valid[k] <= 1'b0;
        else
          r_valid[k] <= w_v[k-1];
      end
    end
  end

  assign bus.stage_en    = ~w_hold;
  assign bus.stage_valid = w_v;
  assign bus.flush       = w_flush;
  assign bus.retire      = w_retire;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_retired_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else if (bus.cnt_clr) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_retired_cnt <= r_retired_cnt + CNT_W'(w_retire);
      r_stall_cnt   <= r_stall_cnt   + CNT_W'(w_hold[0]);
      r_flush_cnt   <= r_flush_cnt   + CNT_W'(w_flush);
    end
  end

  assign bus.retired_cnt = r_retired_cnt;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
`else
  wire w_unused_cnt_clr = bus.cnt_clr;

  assign bus.retired_cnt = '0;
  assign bus.stall_cnt   = '0;
  assign bus.flush_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_pipe_ctrl
// Brief   : Directed bench for pipe_ctrl with a stage-occupancy reference model
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;
  localparam int S  = 5;
  localparam int FD = 1;
  localparam int HZ = 1;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  pipe_ctrl_if #(.STAGES(S), .CNT_W(CW)) bus ();

  pipe_ctrl #(.STAGES(S), .FLUSH_DEPTH(FD), .HAZ_STAGE(HZ), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef PIPE_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(0 * v);
`endif
  endfunction

  // Reference model: occupancy per stage; the deepest stalled stage h freezes 0..h.
  logic [S-1:0] mv;
  int m_ret, m_stl, m_fls;

  always @(negedge clk) begin
    automatic logic [S-1:0] se;
    automatic logic [S-1:0] e_en;
    automatic logic [S-1:0] e_sv;
    automatic logic [S-1:0] nv;
    automatic logic e_fl, e_ret;
    automatic int h;
    if (!rst) begin
      mv = '0; m_ret = 0; m_stl = 0; m_fls = 0;
    end
    se = bus.stall_req | (bus.hazard ? (S'(1) << HZ) : '0);
    h = -1;
    for (int j = 0; j < S; j++) if (se[j]) h = j;
    for (int k = 0; k < S; k++) e_en[k] = (k > h);
    e_fl  = bus.br_taken && (FD > h);
    e_sv  = {mv[S-1:1], bus.fetch_valid};
    e_ret = mv[S-1] && (h < S-1);
    chk("stage_en",    32'(bus.stage_en),    32'(e_en));
    chk("stage_valid", 32'(bus.stage_valid), 32'(e_sv));
    chk("flush",       32'(bus.flush),       32'(e_fl));
    chk("retire",      32'(bus.retire),      32'(e_ret));
    chk("retired_cnt", 32'(bus.retired_cnt), cnt_exp(m_ret));
    chk("stall_cnt",   32'(bus.stall_cnt),   cnt_exp(m_stl));
    chk("flush_cnt",   32'(bus.flush_cnt),   cnt_exp(m_fls));
    if (rst) begin
      nv = '0;
      for (int k = 1; k < S; k++) begin
        if (e_fl && k <= FD)  nv[k] = 1'b0;
        else if (k <= h)      nv[k] = mv[k];
        else if (k == h + 1)  nv[k] = 1'b0;
        else                  nv[k] = e_sv[k-1];
      end
      mv = nv;
      if (bus.cnt_clr) begin
        m_ret = 0; m_stl = 0; m_fls = 0;
      end else begin
        m_ret = (m_ret + int'(e_ret)) % (1 << CW);
        m_stl = (m_stl + int'(!e_en[0])) % (1 << CW);
        m_fls = (m_fls + int'(e_fl)) % (1 << CW);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_valid = 1'b0;
    bus.stall_req   = '0;
    bus.hazard      = 1'b0;
    bus.br_taken    = 1'b0;
    bus.cnt_clr     = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    bus.fetch_valid = 1'b1;

    // Fill: valid bits propagate one stage per cycle.
    for (int i = 0; i < S; i++) begin
      automatic logic [S-1:0] lit = S'((32'd1 << (i + 1)) - 1);
      @(negedge clk);
      chk("fill_valid", 32'(bus.stage_valid), 32'(lit));
      chk("fill_retire", 32'(bus.retire), 32'(i == S-1));
      if (i < S-1) tick();
    end
    repeat (6) tick();
    @(negedge clk);
    chk("ret_after_10", 32'(bus.retired_cnt), cnt_exp(6));

    // Load-use hazard for one cycle.
    tick(); bus.hazard = 1'b1;
    @(negedge clk);
    chk("haz_en", 32'(bus.stage_en), 32'(5'b11100));
    tick(); bus.hazard = 1'b0;
    @(negedge clk);
    chk("haz_bubble", 32'(bus.stage_valid), 32'(5'b11011));
    chk("haz_en_after", 32'(bus.stage_en), 32'(5'b11111));
    chk("haz_stall_cnt", 32'(bus.stall_cnt), cnt_exp(1));

    // Taken branch without hold.
    tick(); bus.br_taken = 1'b1;
    @(negedge clk);
    chk("br_flush", 32'(bus.flush), 32'd1);
    tick(); bus.br_taken = 1'b0;
    @(negedge clk);
    chk("br_valid", 32'(bus.stage_valid), 32'(5'b01101));
    chk("br_flush_cnt", 32'(bus.flush_cnt), cnt_exp(1));

    // Taken branch while the branch stage is held by the hazard.
    tick(); bus.br_taken = 1'b1; bus.hazard = 1'b1;
    @(negedge clk);
    chk("brhz_flush", 32'(bus.flush), 32'd0);
    chk("brhz_en", 32'(bus.stage_en), 32'(5'b11100));
    tick(); bus.br_taken = 1'b0; bus.hazard = 1'b0;
    @(negedge clk);
    chk("brhz_flush_cnt", 32'(bus.flush_cnt), cnt_exp(1));

    // Memory stall in stage 3 for three cycles.
    tick(); bus.stall_req = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st3_en", 32'(bus.stage_en), 32'(5'b10000));
      if (i < 2) tick();
    end
    tick(); bus.stall_req = '0;
    @(negedge clk);
    chk("st3_stall_cnt", 32'(bus.stall_cnt), cnt_exp(5));

    // Refill, clear with retire active, then wrap the retirement counter.
    repeat (6) tick();
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_retire", 32'(bus.retire), 32'd1);
    tick(); bus.cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_ret_cnt", 32'(bus.retired_cnt), cnt_exp(0));
    repeat (15) tick();
    @(negedge clk);
    chk("wrap_15", 32'(bus.retired_cnt), cnt_exp(15));
    tick();
    @(negedge clk);
    chk("wrap_0", 32'(bus.retired_cnt), cnt_exp(0));

    // Asynchronous reset in the middle of a stall.
    tick(); bus.stall_req = 5'b00100;
    #2 rst = 1'b0;
    #1 chk("rst_valid", 32'(bus.stage_valid[S-1:1]), 32'd0);
    chk("rst_retire", 32'(bus.retire), 32'd0);
    tick(); bus.stall_req = '0;
    tick(); rst = 1'b1;
    repeat (4) tick();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
